// File: rtl/adc_mem_capture_pkg.sv
// Shared types and sizing for the dual-channel ADC capture controller.
package adc_mem_capture_pkg;

  localparam int unsigned ADC_W        = 14;
  localparam int unsigned CAP_ADDR_W   = 11;
  localparam int unsigned CAP_DECIM_W  = 8;

  typedef struct packed {
    logic signed [ADC_W-1:0] adc_ch1;
    logic signed [ADC_W-1:0] adc_ch0;
  } adc_sample_t;

  typedef enum logic [1:0] {
    TRIG_IMMEDIATE = 2'b00,
    TRIG_EXT       = 2'b01,
    TRIG_LEVEL_CH0 = 2'b10,
    TRIG_RESERVED  = 2'b11
  } cap_trig_mode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    CAPTURE = 2'b10,
    DONE    = 2'b11
  } cap_state_t;

endpackage

// File: rtl/adc_mem_capture_trig_detect.sv
// Trigger qualification: external rising edge or ch0 rising threshold crossing,
// always gated by the ADC sample strobe.
module adc_mem_capture_trig_detect
  import adc_mem_capture_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic signed [ADC_W-1:0] thresh,
  input  logic                    ext_trig,
  input  logic                    adc_valid,
  input  logic signed [ADC_W-1:0] ch0,
  output logic                    trig_c
);

  logic                    ext_prev;
  logic signed [ADC_W-1:0] prev_ch0;
  logic                    ext_rise;
  logic                    level_cross;

  // History regs; prev_ch0 tracks every valid sample regardless of FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_prev <= 1'b0;
      prev_ch0 <= '0;
    end else begin
      ext_prev <= ext_trig;
      if (adc_valid) prev_ch0 <= ch0;
    end
  end

  assign ext_rise    = ext_trig & ~ext_prev;
  assign level_cross = (prev_ch0 < thresh) && (ch0 >= thresh);

  always_comb begin
    trig_c = 1'b0;
    case (cap_trig_mode_t'(mode))
      TRIG_EXT:       trig_c = adc_valid & ext_rise;
      TRIG_LEVEL_CH0: trig_c = adc_valid & level_cross;
      default:        trig_c = adc_valid;
    endcase
  end

endmodule

// File: rtl/adc_mem_capture.sv
// Capture controller: arms on start, waits for trigger, then writes a programmable
// number of decimated ADC sample pairs into BRAM port A.
module adc_mem_capture
  import adc_mem_capture_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = CAP_ADDR_W,
  parameter int unsigned DECIM_W    = CAP_DECIM_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap_start_i,
  input  logic                  cap_abort_i,
  input  logic [ADDR_WIDTH-1:0] cap_len_i,
  input  logic [1:0]            cap_trig_mode_i,
  input  logic [ADC_W-1:0]      cap_thresh_i,
  input  logic [DECIM_W-1:0]    cap_decim_i,
  input  logic                  ext_trig_i,
  input  logic                  adc_valid_i,
  input  adc_sample_t           adc_data_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output adc_sample_t           mem_data_o,
  output logic                  cap_busy_o,
  output logic                  cap_done_o,
  output logic [ADDR_WIDTH-1:0] cap_count_o
);

  cap_state_t              state;
  logic [ADDR_WIDTH-1:0]   len_q;
  logic [1:0]              mode_q;
  logic signed [ADC_W-1:0] thresh_q;
  logic [DECIM_W-1:0]      decim_q;
  logic [DECIM_W-1:0]      decim_cnt;
  logic                    trig_c;
  logic                    last_c;
  logic                    start_ok_c;

  adc_mem_capture_trig_detect u_trig (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode_q),
    .thresh    (thresh_q),
    .ext_trig  (ext_trig_i),
    .adc_valid (adc_valid_i),
    .ch0       (adc_data_i.adc_ch0),
    .trig_c    (trig_c)
  );

  // The sample about to be stored is the final one of this capture.
  assign last_c     = (cap_count_o == len_q - ADDR_WIDTH'(1));
  assign start_ok_c = cap_start_i && (cap_len_i != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      len_q       <= '0;
      mode_q      <= '0;
      thresh_q    <= '0;
      decim_q     <= '0;
      decim_cnt   <= '0;
      mem_addr_o  <= '0;
      mem_we_o    <= 1'b0;
      mem_data_o  <= '0;
      cap_busy_o  <= 1'b0;
      cap_done_o  <= 1'b0;
      cap_count_o <= '0;
    end else begin
      mem_we_o <= 1'b0;
      if (cap_abort_i) begin
        state      <= IDLE;
        cap_busy_o <= 1'b0;
        cap_done_o <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start_ok_c) begin
              state       <= ARMED;
              len_q       <= cap_len_i;
              mode_q      <= cap_trig_mode_i;
              thresh_q    <= $signed(cap_thresh_i);
              decim_q     <= cap_decim_i;
              cap_count_o <= '0;
              cap_busy_o  <= 1'b1;
              cap_done_o  <= 1'b0;
            end
          end
          ARMED: begin
            // Trigger sample is stored as decimation phase 0.
            if (trig_c) begin
              mem_we_o    <= 1'b1;
              mem_addr_o  <= cap_count_o;
              mem_data_o  <= adc_data_i;
              cap_count_o <= cap_count_o + ADDR_WIDTH'(1);
              decim_cnt   <= (decim_q == '0) ? '0 : DECIM_W'(1);
              if (last_c) begin
                state      <= DONE;
                cap_busy_o <= 1'b0;
                cap_done_o <= 1'b1;
              end else begin
                state <= CAPTURE;
              end
            end
          end
          CAPTURE: begin
            if (adc_valid_i) begin
              decim_cnt <= (decim_cnt == decim_q) ? '0 : decim_cnt + DECIM_W'(1);
              if (decim_cnt == '0) begin
                mem_we_o    <= 1'b1;
                mem_addr_o  <= cap_count_o;
                mem_data_o  <= adc_data_i;
                cap_count_o <= cap_count_o + ADDR_WIDTH'(1);
                if (last_c) begin
                  state      <= DONE;
                  cap_busy_o <= 1'b0;
                  cap_done_o <= 1'b1;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
